// File: rtl/fifo_pkg.sv
// Shared definitions for the dual-clock FIFO pointer controllers.
package fifo_pkg;
  localparam int PTRSIZE         = 10;
  localparam int SYNC_STAGES_DEF = 2;

  typedef logic [PTRSIZE:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction
endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary converter; each binary bit is the XOR of all Gray bits at or above it.
module gray2bin #(
  parameter int WIDTH = 11
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin[i] = ^gray[WIDTH-1:i];
  end
endmodule

// File: rtl/ptr_sync.sv
// Plain flop chain for carrying a Gray pointer across clock domains (synchronous active-low reset).
module ptr_sync #(
  parameter int WIDTH  = 11,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [STAGES-1:0][WIDTH-1:0] sync_q;

  // Nothing but flops between stages so each bit resolves independently.
  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[STAGES-2:0], d};
  end

  assign q = sync_q[STAGES-1];
endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side pointer/flag controller of the async FIFO.
// Optional sticky underflow output enabled by defining FIFO_RD_UNDERFLOW_FLAG_EN.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int ptrsize     = PTRSIZE,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int AE_THRESH   = 4
) (
  input  logic               rclk,
  input  logic               rrst_n,
  input  logic               rd_en,
  input  logic [ptrsize:0]   wptr_gray,
  output logic [ptrsize:0]   rptr_gray,
  output logic [ptrsize-1:0] raddr,
  output logic               ren,
  output logic               rempty,
  output logic               ralmost_empty,
  output logic [ptrsize:0]   rlevel
`ifdef FIFO_RD_UNDERFLOW_FLAG_EN
  ,
  output logic               rd_underflow
`endif
);
  typedef logic [ptrsize:0] rptr_t;

  localparam rptr_t AE_LVL = rptr_t'(AE_THRESH);

  rptr_t rbin, rbin_next, rgray_next;
  rptr_t wgray_s, wbin_s, lvl_next;
  logic  rinc;

  ptr_sync #(.WIDTH(ptrsize+1), .STAGES(SYNC_STAGES)) u_wsync (
    .clk   (rclk),
    .rst_n (rrst_n),
    .d     (wptr_gray),
    .q     (wgray_s)
  );

  gray2bin #(.WIDTH(ptrsize+1)) u_g2b (
    .gray (wgray_s),
    .bin  (wbin_s)
  );

  assign rinc       = rd_en & ~rempty;
  assign ren        = rinc;
  assign raddr      = rbin[ptrsize-1:0];
  assign rbin_next  = rbin + rptr_t'(rinc);
  assign rgray_next = rbin_next ^ (rbin_next >> 1);
  assign lvl_next   = wbin_s - rbin_next;

  // Flags compare against the pre-edge wgray_s, so a pointer arriving on the
  // same edge as the last read leaves rempty set one extra cycle (safe side).
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      rbin          <= '0;
      rptr_gray     <= '0;
      rempty        <= 1'b1;
      ralmost_empty <= 1'b1;
      rlevel        <= '0;
    end else begin
      rbin          <= rbin_next;
      rptr_gray     <= rgray_next;
      rempty        <= (rgray_next == wgray_s);
      ralmost_empty <= (lvl_next <= AE_LVL);
      rlevel        <= lvl_next;
    end
  end

`ifdef FIFO_RD_UNDERFLOW_FLAG_EN
  always_ff @(posedge rclk) begin
    if (!rrst_n)              rd_underflow <= 1'b0;
    else if (rd_en && rempty) rd_underflow <= 1'b1;
  end
`endif
endmodule
